// File: rtl/alu_op_sequencer.sv
// FIFO-buffered issue/collect sequencer for the 2-bit ALU: FIFO -> S1 issue register -> S2 result register.
// Optional result self-check enabled by defining ALU_SEQ_CHECK_EN; otherwise err is tied to 0.
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_opcode,
    input  logic [1:0]               in_a,
    input  logic [1:0]               in_b,
    output logic [1:0]               alu_a,
    output logic [1:0]               alu_b,
    output logic [1:0]               alu_opcode,
    output logic                     alu_rst,
    input  logic [3:0]               alu_r,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_result,
    output logic [1:0]               out_opcode,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [5:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          s1_v_q;
    logic [5:0]    s1_q;          // {opcode, a, b}
    logic          out_valid_q;
    logic [5:0]    s2_q;          // {opcode, result}
    logic          push, pop, s2_ld, s1_adv;

    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign s2_ld    = s1_v_q & (~out_valid_q | out_ready);
    assign s1_adv   = ~s1_v_q | s2_ld;
    assign pop      = s1_adv & (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            s1_v_q      <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            s2_q        <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_opcode, in_a, in_b};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            // S1 keeps stale operands when it empties so alu_* only change on a real issue
            if (s1_adv) begin
                s1_v_q <= pop;
                if (pop)
                    s1_q <= mem_q[rd_ptr_q];
            end
            if (s2_ld) begin
                out_valid_q <= 1'b1;
                s2_q        <= {s1_q[5:4], alu_r};
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign alu_opcode = s1_q[5:4];
    assign alu_a      = s1_q[3:2];
    assign alu_b      = s1_q[1:0];
    assign alu_rst    = ~s1_v_q;
    assign out_valid  = out_valid_q;
    assign out_opcode = s2_q[5:4];
    assign out_result = s2_q[3:0];
    assign level      = level_q;

`ifdef ALU_SEQ_CHECK_EN
    logic err_q;

    function automatic logic [3:0] alu_expect(input logic [1:0] op, input logic [1:0] a,
                                              input logic [1:0] b);
        case (op)
            2'b00:   return {2'b00, a} + {2'b00, b};
            2'b01:   return {2'b00, a} - {2'b00, b};
            2'b10:   return {2'b00, a & b};
            default: return {2'b00, a | b};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else if (s2_ld && ($isunknown(alu_r) || (alu_r != alu_expect(s1_q[5:4], s1_q[3:2], s1_q[1:0]))))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
